// File: rtl/vme_master_pkg.sv
// Shared types and constants for the VME strobe bus masters.
package vme_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic C_OP_READ  = 1'b0;
  localparam logic C_OP_WRITE = 1'b1;

  localparam int unsigned C_DEFAULT_TIMEOUT = 32'd255;

  // Width of a counter able to hold the value TIMEOUT.
  function automatic int unsigned tmo_width(input int unsigned timeout);
    return $clog2(timeout + 32'd1);
  endfunction

endpackage

// File: rtl/vme_strobe_master_if.sv
// Request/response stream plus VME strobe bus, seen from the master (design) and slave (environment) sides.
interface vme_strobe_master_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wr_data;
  logic [DATA_WIDTH-1:0] bus_rd_data;
  logic                  bus_rd_mem;
  logic                  bus_wr_mem;
  logic                  bus_rd_done;
  logic                  bus_wr_done;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  bus_rd_data, bus_rd_done, bus_wr_done,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_addr, bus_wr_data, bus_rd_mem, bus_wr_mem
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output bus_rd_data, bus_rd_done, bus_wr_done,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_addr, bus_wr_data, bus_rd_mem, bus_wr_mem
  );

endinterface

// File: rtl/vme_master_timeout.sv
// Loadable down-counter for access timeouts: load arms it, en counts down,
// expire flags the last waiting cycle.
module vme_master_timeout
  import vme_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = C_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = tmo_width(TIMEOUT);
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT - 32'd1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear beats load beats decrement; never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = LOAD_VAL;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/vme_strobe_master.sv
// Converts a valid/ready request stream into single-cycle VME read/write strobes,
// waits for the matching done and returns a response, or an error on timeout.
module vme_strobe_master
  import vme_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = C_DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  vme_strobe_master_if.master bus,
  output logic [15:0]         timeout_cnt
);

  state_e                state_q, state_d;
  logic                  op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_mem_q, rd_mem_d;
  logic                  wr_mem_q, wr_mem_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [15:0]           tcnt_q, tcnt_d;
  logic                  done_match;
  logic                  tmo_clr, tmo_load, tmo_en, tmo_expire;

  vme_master_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmo_clr),
    .load_i   (tmo_load),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  // Next-state and next-output logic; only WAIT looks at the done inputs.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_mem_d    = 1'b0;
    wr_mem_d    = 1'b0;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tcnt_d      = tcnt_q;
    tmo_clr     = 1'b0;
    tmo_load    = 1'b0;
    tmo_en      = 1'b0;
    done_match  = (op_q == C_OP_WRITE) ? bus.bus_wr_done : bus.bus_rd_done;

    case (state_q)
      IDLE: begin
        tmo_clr = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          state_d     = STROBE;
          op_d        = bus.req_write;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          rd_mem_d    = (bus.req_write == C_OP_READ);
          wr_mem_d    = (bus.req_write == C_OP_WRITE);
          req_ready_d = 1'b0;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      STROBE: begin
        tmo_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        // A done in the expiring cycle still wins over the timeout.
        if (done_match) begin
          rsp_rdata_d = (op_q == C_OP_READ) ? bus.bus_rd_data : {DATA_WIDTH{1'b0}};
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (tmo_expire) begin
          rsp_rdata_d = {DATA_WIDTH{1'b0}};
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
          if (tcnt_q != 16'hFFFF) begin
            tcnt_d = tcnt_q + 16'd1;
          end else begin
            tcnt_d = tcnt_q;
          end
        end else begin
          tmo_en = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= C_OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_mem_q    <= 1'b0;
      wr_mem_q    <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tcnt_q      <= 16'd0;
    end else begin
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_mem_q    <= rd_mem_d;
      wr_mem_q    <= wr_mem_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_data = wdata_q;
  assign bus.bus_rd_mem  = rd_mem_q;
  assign bus.bus_wr_mem  = wr_mem_q;
  assign timeout_cnt     = tcnt_q;

endmodule
